// File: rtl/mdu_sequencer_pkg.sv
// Shared constants for the iterative multiply/divide sequencer:
// ALU opcodes, MDU operation codes and FSM state encodings.
package mdu_sequencer_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_NOP = 3'b000;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/result handshake plus the borrowed-ALU operand/result signals.
// slave = the sequencer, master = the requester / datapath side.
interface mdu_sequencer_if #(parameter int unsigned WIDTH = 32);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             alu_sel;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_out;

  modport slave (
    input  start, op, rs_val, rt_val, alu_out,
    output busy, done, div_by_zero, hi, lo, alu_sel, alu_in1, alu_in2, alu_op
  );

  modport master (
    output start, op, rs_val, rt_val, alu_out,
    input  busy, done, div_by_zero, hi, lo, alu_sel, alu_in1, alu_in2, alu_op
  );

endinterface

// File: rtl/mdu_iter_counter.sv
// Iteration counter for the MDU: clears outside RUN, counts each step,
// flags the final step (count == WIDTH-1).
module mdu_iter_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MULTU/DIVU unit: one shift-add or restoring-divide step per RUN
// cycle through the shared external ALU, results latched into HI/LO.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mdu_sequencer_if.slave bus
);

  logic [1:0]       state;
  logic             op_q;
  logic             dbz_q;
  logic             last;
  logic [WIDTH-1:0] p_q, q_q, m_q, hi_q, lo_q;
  logic [WIDTH-1:0] p_nxt, q_nxt, t, sum, in1, in2;
  logic [2:0]       aop;
  logic             carry, ok;

  mdu_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state != S_RUN),
    .en    (state == S_RUN),
    .last  (last)
  );

  // Step datapath; the ALU result comes back combinationally in the same cycle.
  always_comb begin
    in1   = '0;
    in2   = '0;
    aop   = ALU_NOP;
    p_nxt = p_q;
    q_nxt = q_q;
    t     = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
    sum   = p_q;
    carry = 1'b0;
    ok    = 1'b0;
    if (state == S_RUN) begin
      if (op_q == OP_MULTU) begin
        in1 = p_q;
        in2 = m_q;
        aop = ALU_ADD;
        if (q_q[0]) begin
          sum   = bus.alu_out;
          carry = (bus.alu_out < p_q);
        end
        p_nxt = {carry, sum[WIDTH-1:1]};
        q_nxt = {sum[0], q_q[WIDTH-1:1]};
      end else begin
        in1   = t;
        in2   = m_q;
        aop   = ALU_SUB;
        ok    = p_q[WIDTH-1] | (bus.alu_out <= t);
        p_nxt = ok ? bus.alu_out : t;
        q_nxt = {q_q[WIDTH-2:0], ok};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= OP_MULTU;
      dbz_q <= 1'b0;
      p_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_DIVU && bus.rt_val == '0) begin
              hi_q  <= bus.rs_val;
              lo_q  <= '1;
              dbz_q <= 1'b1;
              state <= S_DONE;
            end else begin
              op_q  <= bus.op;
              p_q   <= '0;
              q_q   <= (bus.op == OP_MULTU) ? bus.rt_val : bus.rs_val;
              m_q   <= (bus.op == OP_MULTU) ? bus.rs_val : bus.rt_val;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          p_q <= p_nxt;
          q_q <= q_nxt;
          if (last) begin
            hi_q  <= p_nxt;
            lo_q  <= q_nxt;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          dbz_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.alu_sel     = (state == S_RUN);
  assign bus.alu_in1     = in1;
  assign bus.alu_in2     = in2;
  assign bus.alu_op      = aop;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a behavioural add/sub ALU attached
// to the borrowed operand bus.
module tb_mdu_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mdu_sequencer_if #(.WIDTH(32)) bus();

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shared ALU
  always_comb begin
    case (bus.alu_op)
      3'b010:  bus.alu_out = bus.alu_in1 + bus.alu_in2;
      3'b110:  bus.alu_out = bus.alu_in1 - bus.alu_in2;
      default: bus.alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Results of the last run_op
  int          lat, busy_n, sel_n, sub_n;
  logic        got, dbz;
  logic [31:0] r_hi, r_lo;

  task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input int repulse_at);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; busy_n = 0; sel_n = 0; sub_n = 0; got = 1'b0; dbz = 1'b0;
    for (int n = 1; n <= 100 && !got; n++) begin
      @(negedge clk);
      if (n == repulse_at) begin
        bus.start = 1'b1; bus.op = 1'b1; bus.rs_val = 32'd9; bus.rt_val = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_n++;
      if (bus.alu_sel) sel_n++;
      if (bus.alu_sel && bus.alu_op == 3'b110) sub_n++;
      if (bus.done) begin
        got = 1'b1; lat = n; dbz = bus.div_by_zero; r_hi = bus.hi; r_lo = bus.lo;
      end
    end
    bus.start = 1'b0;
    check({tag, " done_seen"}, 64'(got), 64'd1);
    @(negedge clk);
    check({tag, " done_pulse"}, {63'd0, bus.done}, 64'd0);
    check({tag, " idle_after"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.rs_val = '0; bus.rt_val = '0;
    repeat (2) @(negedge clk);
    check("rst busy", {63'd0, bus.busy}, 64'd0);
    check("rst done", {63'd0, bus.done}, 64'd0);
    check("rst dbz", {63'd0, bus.div_by_zero}, 64'd0);
    check("rst alu_sel", {63'd0, bus.alu_sel}, 64'd0);
    check("rst hi", 64'(bus.hi), 64'd0);
    check("rst lo", 64'(bus.lo), 64'd0);
    check("rst alu_in1", 64'(bus.alu_in1), 64'd0);
    check("rst alu_in2", 64'(bus.alu_in2), 64'd0);
    check("rst alu_op", 64'(bus.alu_op), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1. MULTU 7 x 6
    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 0);
    check("mul7x6 lat", 64'(lat), 64'd33);
    check("mul7x6 busy", 64'(busy_n), 64'd33);
    check("mul7x6 hi", 64'(r_hi), 64'd0);
    check("mul7x6 lo", 64'(r_lo), 64'd42);
    check("mul7x6 dbz", 64'(dbz), 64'd0);
    check("mul7x6 hold", {bus.hi, bus.lo}, 64'd42);

    // 2. MULTU all-ones (carry path)
    run_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("mulmax hi", 64'(r_hi), 64'hFFFF_FFFE);
    check("mulmax lo", 64'(r_lo), 64'h0000_0001);

    // 3. DIVU 100 / 7
    run_op("div100", 1'b1, 32'd100, 32'd7, 0);
    check("div100 lo", 64'(r_lo), 64'd14);
    check("div100 hi", 64'(r_hi), 64'd2);
    check("div100 sub_cycles", 64'(sub_n), 64'd32);
    check("div100 sel_cycles", 64'(sel_n), 64'd32);
    check("div100 lat", 64'(lat), 64'd33);

    // 4. DIVU all-ones / 1 (top-bit path)
    run_op("divmax", 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
    check("divmax lo", 64'(r_lo), 64'hFFFF_FFFF);
    check("divmax hi", 64'(r_hi), 64'd0);

    // 5. DIVU by zero
    run_op("div0", 1'b1, 32'd5, 32'd0, 0);
    check("div0 lat", 64'(lat), 64'd1);
    check("div0 dbz", 64'(dbz), 64'd1);
    check("div0 hi", 64'(r_hi), 64'd5);
    check("div0 lo", 64'(r_lo), 64'hFFFF_FFFF);
    check("div0 sel_cycles", 64'(sel_n), 64'd0);
    check("div0 dbz_clear", {63'd0, bus.div_by_zero}, 64'd0);

    // 6a. start re-pulsed mid-run is ignored
    run_op("repulse", 1'b0, 32'd3, 32'd5, 5);
    check("repulse lat", 64'(lat), 64'd33);
    check("repulse hi", 64'(r_hi), 64'd0);
    check("repulse lo", 64'(r_lo), 64'd15);
    check("repulse dbz", 64'(dbz), 64'd0);

    // 6b. reset at k+10 of a new op aborts it
    bus.start = 1'b1; bus.op = 1'b0; bus.rs_val = 32'd11; bus.rt_val = 32'd13;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort busy_before", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort busy", {63'd0, bus.busy}, 64'd0);
    check("abort hi", 64'(bus.hi), 64'd0);
    check("abort lo", 64'(bus.lo), 64'd0);
    check("abort alu_sel", {63'd0, bus.alu_sel}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done || bus.busy) got = 1'b1;
    end
    check("abort no_done", 64'(got), 64'd0);

    // 6c. a fresh op completes normally
    run_op("after", 1'b0, 32'h1234_5678, 32'h10, 0);
    check("after lat", 64'(lat), 64'd33);
    check("after hi", 64'(r_hi), 64'd1);
    check("after lo", 64'(r_lo), 64'h2345_6780);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
